// File: rtl/pl_adc_pkg.sv
// Shared types and constants for the parallel CMOS ADC emulator.
// Mode encoding, pattern constants, LFSR definition, FSM states.
package pl_adc_pkg;

  localparam int DATA_W = 14;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_CONST = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  localparam logic [DATA_W-1:0] CHK_A     = 14'h2AAA;
  localparam logic [DATA_W-1:0] CHK_B     = 14'h1555;
  localparam logic [DATA_W-1:0] LFSR_SEED = 14'h0001;
  // taps 14,5,3,1 -> bits 13,4,2,0
  localparam logic [DATA_W-1:0] LFSR_TAPS = 14'h2015;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_FLUSH,
    ST_DONE
  } state_e;

  function automatic logic [DATA_W-1:0] lfsr_step(
    input logic [DATA_W-1:0] s
  );
    return {s[DATA_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pl_adc_pattern_gen.sv
// Deterministic sample source: ramp, constant, checkerboard, LFSR.
// Mode and constant are latched on seed and held for the burst.
module pl_adc_pattern_gen
  import pl_adc_pkg::*;
(
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Seed,
  input  logic              i_Adv,
  input  mode_e             i_Mode,
  input  logic [DATA_W-1:0] i_Const,
  output logic [DATA_W-1:0] o_Sample
);

  mode_e             r_mode;
  logic [DATA_W-1:0] r_const;
  logic [DATA_W-1:0] r_ramp;
  logic [DATA_W-1:0] r_lfsr;
  logic              r_chk;

  // Seed latches config and restarts every pattern; advance steps them.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_mode  <= MODE_RAMP;
      r_const <= '0;
      r_ramp  <= '0;
      r_lfsr  <= LFSR_SEED;
      r_chk   <= 1'b0;
    end else if (i_Seed) begin
      r_mode  <= i_Mode;
      r_const <= i_Const;
      r_ramp  <= '0;
      r_lfsr  <= LFSR_SEED;
      r_chk   <= 1'b0;
    end else if (i_Adv) begin
      r_ramp  <= r_ramp + 1'b1;
      r_lfsr  <= lfsr_step(r_lfsr);
      r_chk   <= ~r_chk;
    end
  end

  // Select the current sample of the latched pattern.
  always_comb begin
    o_Sample = r_ramp;
    unique case (r_mode)
      MODE_RAMP:  o_Sample = r_ramp;
      MODE_CONST: o_Sample = r_const;
      MODE_CHECK: o_Sample = r_chk ? CHK_B : CHK_A;
      MODE_LFSR:  o_Sample = r_lfsr;
      default:    o_Sample = r_ramp;
    endcase
  end

endmodule

// File: rtl/pl_adc_cmos_emu.sv
// Transmit side of the 14-bit CMOS ADC bus for loopback testing.
// ADC_EMU_TWOS_COMP_EN: invert the MSB of valid samples (two's complement).
module pl_adc_cmos_emu
  import pl_adc_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int BURST_LEN = 1024,
  parameter int PIPE_LAT  = 4
)(
  input  logic              i_CMOS_Clk,
  input  logic              i_Rst,
  input  logic              i_ADC_Work,
  input  logic [1:0]        i_Mode,
  input  logic [DATA_W-1:0] i_Const,
  output logic [DATA_W-1:0] o_CMOS_Data,
  output logic              o_CMOS_Valid,
  output logic              o_Busy,
  output logic              o_ADC_Done
);

  localparam logic [15:0] LAST_SMP = 16'(BURST_LEN - 1);
  localparam logic [15:0] LAST_FLU = 16'(PIPE_LAT - 1);

`ifdef ADC_EMU_TWOS_COMP_EN
  localparam logic [DATA_W-1:0] FMT_XOR = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] FMT_XOR = '0;
`endif

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_work_d;
  logic [15:0]       r_cnt;
  logic              w_start;
  logic              w_seed;
  logic              w_adv;
  logic              w_vld_in;
  logic              w_cnt_clr;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [DATA_W-1:0] w_sample;
  logic [DATA_W-1:0] r_dly_data [PIPE_LAT];
  logic              r_dly_vld  [PIPE_LAT];

  assign w_start = i_ADC_Work & ~r_work_d & (r_state == ST_IDLE);

  // Request edge detector; resets high so a held request cannot start.
  always_ff @(posedge i_CMOS_Clk) begin
    if (i_Rst) r_work_d <= 1'b1;
    else       r_work_d <= i_ADC_Work;
  end

  // FSM state register.
  always_ff @(posedge i_CMOS_Clk) begin
    if (i_Rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_CONV;
      ST_CONV:  if (r_cnt == LAST_SMP) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_cnt == LAST_FLU) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; busy/done feed the registered output stage.
  always_comb begin
    w_seed     = w_start;
    w_adv      = (r_state == ST_CONV);
    w_vld_in   = (r_state == ST_CONV);
    w_cnt_clr  = (w_state_nxt != r_state);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (r_state == ST_DONE);
  end

  // Per-state cycle counter, cleared on every state change.
  always_ff @(posedge i_CMOS_Clk) begin
    if (i_Rst || w_cnt_clr) r_cnt <= '0;
    else if (r_state == ST_CONV || r_state == ST_FLUSH)
      r_cnt <= r_cnt + 16'd1;
  end

  pl_adc_pattern_gen u_gen (
    .i_Clk    (i_CMOS_Clk),
    .i_Rst    (i_Rst),
    .i_Seed   (w_seed),
    .i_Adv    (w_adv),
    .i_Mode   (mode_e'(i_Mode)),
    .i_Const  (i_Const),
    .o_Sample (w_sample)
  );

  // Emulated ADC pipeline: data and valid shift together.
  always_ff @(posedge i_CMOS_Clk) begin
    if (i_Rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_dly_data[i] <= '0;
        r_dly_vld[i]  <= 1'b0;
      end
    end else begin
      r_dly_data[0] <= w_sample;
      r_dly_vld[0]  <= w_vld_in;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_dly_data[i] <= r_dly_data[i-1];
        r_dly_vld[i]  <= r_dly_vld[i-1];
      end
    end
  end

  // Output register: format valid samples, force idle bus to zero.
  always_ff @(posedge i_CMOS_Clk) begin
    if (i_Rst) begin
      o_CMOS_Data  <= '0;
      o_CMOS_Valid <= 1'b0;
      o_Busy       <= 1'b0;
      o_ADC_Done   <= 1'b0;
    end else begin
      o_CMOS_Valid <= r_dly_vld[PIPE_LAT-1];
      o_CMOS_Data  <= r_dly_vld[PIPE_LAT-1] ?
                      (r_dly_data[PIPE_LAT-1] ^ FMT_XOR) : '0;
      o_Busy       <= w_busy_nxt;
      o_ADC_Done   <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_pl_adc_cmos_emu.sv
// Bench for pl_adc_cmos_emu: short burst instance plus a wrap instance.
// Expected samples are queued at stimulus time and popped on valid.
module tb_pl_adc_cmos_emu;

  logic        clk = 1'b0;
  logic        rst;
  logic        work_a, work_b;
  logic [1:0]  mode_a, mode_b;
  logic [13:0] const_a, const_b;
  logic [13:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;

  int tests = 0;
  int fails = 0;
  logic [13:0] q[$];

`ifdef ADC_EMU_TWOS_COMP_EN
  localparam logic [13:0] FLIP = 14'h2000;
`else
  localparam logic [13:0] FLIP = 14'h0000;
`endif

  always #5 clk = ~clk;

  pl_adc_cmos_emu #(
    .DATA_W(14), .BURST_LEN(8), .PIPE_LAT(4)
  ) dut_a (
    .i_CMOS_Clk   (clk),
    .i_Rst        (rst),
    .i_ADC_Work   (work_a),
    .i_Mode       (mode_a),
    .i_Const      (const_a),
    .o_CMOS_Data  (data_a),
    .o_CMOS_Valid (valid_a),
    .o_Busy       (busy_a),
    .o_ADC_Done   (done_a)
  );

  pl_adc_cmos_emu #(
    .DATA_W(14), .BURST_LEN(16386), .PIPE_LAT(4)
  ) dut_b (
    .i_CMOS_Clk   (clk),
    .i_Rst        (rst),
    .i_ADC_Work   (work_b),
    .i_Mode       (mode_b),
    .i_Const      (const_b),
    .o_CMOS_Data  (data_b),
    .o_CMOS_Valid (valid_b),
    .o_Busy       (busy_b),
    .o_ADC_Done   (done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] lfsr_nx(input logic [13:0] s);
    logic fb;
    fb = s[13] ^ s[4] ^ s[2] ^ s[0];
    return {s[12:0], fb};
  endfunction

  task automatic test_reset();
    rst = 1'b1; work_a = 1'b1; work_b = 1'b1;
    repeat (3) tick();
    tests++; if (data_a !== 14'h0) begin fails++;
      $display("FAIL rst_data got %h want 0000", data_a); end
    tests++; if (valid_a !== 1'b0) begin fails++;
      $display("FAIL rst_valid got %b want 0", valid_a); end
    tests++; if (busy_a !== 1'b0) begin fails++;
      $display("FAIL rst_busy got %b want 0", busy_a); end
    tests++; if (done_a !== 1'b0) begin fails++;
      $display("FAIL rst_done got %b want 0", done_a); end
    tests++; if (valid_b !== 1'b0 || busy_b !== 1'b0) begin fails++;
      $display("FAIL rst_b got v%b b%b want v0 b0", valid_b, busy_b); end
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      tests++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin fails++;
        $display("FAIL rst_held_req got a%b b%b want 0 0", busy_a, busy_b); end
    end
    work_a = 1'b0; work_b = 1'b0;
    tick();
  endtask

  task automatic test_ramp();
    logic [13:0] e;
    mode_a = 2'd0;
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(14'(i) ^ FLIP);
    work_a = 1'b1;
    tick();
    tests++; if (busy_a !== 1'b1) begin fails++;
      $display("FAIL ramp_busy_start got %b want 1", busy_a); end
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 4) work_a = 1'b0;
      tests++; if (valid_a !== (n >= 5 && n <= 12)) begin fails++;
        $display("FAIL ramp_valid n=%0d got %b", n, valid_a); end
      tests++; if (done_a !== (n == 13)) begin fails++;
        $display("FAIL ramp_done n=%0d got %b", n, done_a); end
      tests++; if (busy_a !== (n <= 12)) begin fails++;
        $display("FAIL ramp_busy n=%0d got %b", n, busy_a); end
      if (valid_a === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        tests++; if (data_a !== e) begin fails++;
          $display("FAIL ramp_data n=%0d got %h want %h", n, data_a, e); end
      end
    end
    tests++; if (q.size() != 0) begin fails++;
      $display("FAIL ramp_count left %0d want 0", q.size()); end
  endtask

  task automatic test_checker();
    logic [13:0] e;
    bit seen;
    mode_a = 2'd2;
    q.delete();
    for (int i = 0; i < 8; i++)
      q.push_back(((i % 2) == 0 ? 14'h2AAA : 14'h1555) ^ FLIP);
    work_a = 1'b1;
    tick();
    work_a = 1'b0;
    seen = 1'b0;
    for (int n = 1; n <= 30 && !seen; n++) begin
      tick();
      if (valid_a === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        tests++; if (data_a !== e) begin fails++;
          $display("FAIL chk_data got %h want %h", data_a, e); end
      end
      if (done_a === 1'b1) seen = 1'b1;
    end
    tests++; if (!seen || q.size() != 0) begin fails++;
      $display("FAIL chk_end done %b left %0d want 1 0", seen, q.size()); end
  endtask

  task automatic test_lfsr_back_to_back();
    logic [13:0] e, s;
    bit seen;
    mode_a = 2'd3;
    work_a = 1'b1;
    for (int b = 0; b < 2; b++) begin
      q.delete();
      s = 14'h0001;
      for (int i = 0; i < 8; i++) begin
        q.push_back(s ^ FLIP);
        s = lfsr_nx(s);
      end
      tick();
      tests++; if (busy_a !== 1'b1) begin fails++;
        $display("FAIL lfsr_start b=%0d busy %b want 1", b, busy_a); end
      work_a = 1'b0;
      seen = 1'b0;
      for (int n = 1; n <= 30 && !seen; n++) begin
        tick();
        if (valid_a === 1'b1 && q.size() > 0) begin
          e = q.pop_front();
          tests++; if (data_a !== e) begin fails++;
            $display("FAIL lfsr_data b=%0d got %h want %h", b, data_a, e); end
        end
        if (done_a === 1'b1) seen = 1'b1;
      end
      tests++; if (!seen || q.size() != 0) begin fails++;
        $display("FAIL lfsr_end b=%0d done %b left %0d", b, seen, q.size()); end
      work_a = (b == 0);
    end
    work_a = 1'b0;
    tick();
  endtask

  task automatic test_const();
    logic [13:0] e;
    mode_a = 2'd1;
    const_a = 14'h0123;
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(14'h0123 ^ FLIP);
    work_a = 1'b1;
    tick();
    work_a = 1'b0;
    const_a = 14'h3FFF;
    for (int n = 1; n <= 18; n++) begin
      tick();
      if (valid_a === 1'b1) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL const_extra got %h want none", data_a);
        end else begin
          e = q.pop_front();
          tests++; if (data_a !== e) begin fails++;
            $display("FAIL const_data got %h want %h", data_a, e); end
        end
      end else begin
        tests++; if (data_a !== 14'h0000) begin fails++;
          $display("FAIL const_idle got %h want 0000", data_a); end
      end
    end
    tests++; if (q.size() != 0) begin fails++;
      $display("FAIL const_count left %0d want 0", q.size()); end
  endtask

  task automatic test_abort();
    bit seen;
    mode_a = 2'd0;
    work_a = 1'b1;
    tick();
    work_a = 1'b0;
    tick();
    work_a = 1'b1;
    repeat (3) tick();
    tick();
    tests++; if (valid_a !== 1'b1 || data_a !== (14'h0000 ^ FLIP)) begin
      fails++;
      $display("FAIL abort_first got v%b %h want v1 %h",
               valid_a, data_a, 14'h0000 ^ FLIP);
    end
    tick();
    tests++; if (data_a !== (14'h0001 ^ FLIP)) begin fails++;
      $display("FAIL abort_second got %h want %h", data_a, 14'h0001 ^ FLIP); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (valid_a !== 1'b0 || data_a !== 14'h0) begin fails++;
      $display("FAIL abort_out got v%b %h want v0 0000", valid_a, data_a); end
    tests++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin fails++;
      $display("FAIL abort_flags got b%b d%b want 0 0", busy_a, done_a); end
    for (int n = 0; n < 20; n++) begin
      tick();
      tests++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin fails++;
        $display("FAIL abort_quiet n=%0d b%b d%b want 0 0", n, busy_a, done_a); end
    end
    work_a = 1'b0;
    tick();
    work_a = 1'b1;
    tick();
    tests++; if (busy_a !== 1'b1) begin fails++;
      $display("FAIL abort_restart got %b want 1", busy_a); end
    work_a = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      tick();
      if (done_a === 1'b1) seen = 1'b1;
    end
    tests++; if (!seen) begin fails++;
      $display("FAIL abort_done_timeout got 0 want 1"); end
  endtask

  task automatic test_wrap();
    logic [13:0] e;
    bit seen;
    int cnt;
    mode_b = 2'd0;
    q.delete();
    for (int i = 0; i < 16386; i++) q.push_back(14'(i) ^ FLIP);
    work_b = 1'b1;
    tick();
    work_b = 1'b0;
    seen = 1'b0;
    cnt = 0;
    for (int n = 1; n <= 16410 && !seen; n++) begin
      tick();
      if (valid_b === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        cnt++;
        if (cnt > 16383) begin
          tests++; if (data_b !== e) begin fails++;
            $display("FAIL wrap_tail got %h want %h", data_b, e); end
        end else if (data_b !== e) begin
          tests++; fails++;
          $display("FAIL wrap_data got %h want %h", data_b, e);
        end
      end
      if (done_b === 1'b1) seen = 1'b1;
    end
    tests++; if (!seen || cnt != 16386) begin fails++;
      $display("FAIL wrap_end done %b count %0d want 1 16386", seen, cnt); end
  endtask

  initial begin
    rst = 1'b1;
    work_a = 1'b0; work_b = 1'b0;
    mode_a = 2'd0; mode_b = 2'd0;
    const_a = 14'h0; const_b = 14'h0;
    test_reset();
    test_ramp();
    test_checker();
    test_lfsr_back_to_back();
    test_const();
    test_abort();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
